// File: rtl/key_matrix_scanner.sv
// ============================================================================
// Module      : key_matrix_scanner
// Description : 4x4 active-low key matrix scanner with per-frame debounce and
//               a valid/ack key-code handshake with overrun indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_matrix_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] KeyCol,
    output logic [3:0] KeyRow,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    input  logic       KeyAck,
    output logic       KeyPressed,
    output logic       Overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_q,  div_d;
    logic [1:0]       row_q,  row_d;
    logic [3:0]       key_row_q;
    logic [1:0]       zcnt_q, zcnt_d;
    logic [3:0]       first_q, first_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q;
    logic             valid_q;
    logic             overrun_q;

    logic       tick;
    logic       frame_end;
    logic [2:0] zeros_now;
    logic [1:0] col_now;
    logic [2:0] zeros_total;
    logic [3:0] frame_code;
    logic       frame_none;
    logic       frame_one;
    logic       key_event;

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (row_q == 2'd3);

    // Count the closed columns on the driven row and find the lowest one.
    always_comb begin
        zeros_now = 3'd0;
        col_now   = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!KeyCol[c]) begin
                zeros_now = zeros_now + 3'd1;
                col_now   = 2'(c);
            end
        end
        zeros_total = {1'b0, zcnt_q} + zeros_now;
        frame_code  = (zcnt_q != 2'd0) ? first_q : {row_q, col_now};
        frame_none  = (zeros_total == 3'd0);
        frame_one   = (zeros_total == 3'd1);
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        row_d   = tick ? row_q + 2'd1 : row_q;
        zcnt_d  = zcnt_q;
        first_d = first_q;
        if (tick) begin
            if (frame_end) begin
                zcnt_d  = 2'd0;
                first_d = 4'd0;
            end else begin
                // Saturate at two: only none/one/many matters for the frame result.
                zcnt_d = (zeros_total >= 3'd2) ? 2'd2 : zeros_total[1:0];
                if (zcnt_q == 2'd0 && zeros_now != 3'd0) begin
                    first_d = {row_q, col_now};
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_event  = 1'b0;
        KeyPressed = (state_q == S_HELD) || (state_q == S_RELEASE);
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_one) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_W'(1);
                        if (CNT_TARGET == CNT_W'(1)) begin
                            state_d   = S_HELD;
                            key_event = 1'b1;
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_one && frame_code == cand_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_TARGET) begin
                            state_d   = S_HELD;
                            key_event = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (frame_none) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (CNT_TARGET == CNT_W'(1)) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (frame_none) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_TARGET) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_q     <= 2'd0;
            key_row_q <= 4'b1110;
            zcnt_q    <= 2'd0;
            first_q   <= 4'd0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cand_q    <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            key_row_q <= ~(4'b0001 << row_d);
            zcnt_q    <= zcnt_d;
            first_q   <= first_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            // A new key beats a same-cycle ack, so the ack only clears when no event.
            overrun_q <= key_event && valid_q && !KeyAck;
            if (key_event) begin
                code_q  <= frame_code;
                valid_q <= 1'b1;
            end else if (KeyAck && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign KeyRow   = key_row_q;
    assign KeyCode  = code_q;
    assign KeyValid = valid_q;
    assign Overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
// ============================================================================
// Module      : tb_key_matrix_scanner
// Description : Self-checking bench for key_matrix_scanner with a modelled
//               key matrix and a queue of expected key codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_matrix_scanner;

    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  KeyCol;
    logic [3:0]  KeyRow;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic        KeyAck = 1'b0;
    logic        KeyPressed;
    logic        Overrun;

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ov_count = 0;
    int          ov0;

    key_matrix_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .KeyCol     (KeyCol),
        .KeyRow     (KeyRow),
        .KeyCode    (KeyCode),
        .KeyValid   (KeyValid),
        .KeyAck     (KeyAck),
        .KeyPressed (KeyPressed),
        .Overrun    (Overrun)
    );

    always #5 clk = ~clk;

    // Passive matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        KeyCol = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!KeyRow[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) KeyCol[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (Overrun === 1'b1) ov_count <= ov_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop_expected();
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got event code %0d, expected no event", KeyCode);
            exp_code = 4'hX;
        end else begin
            exp_code = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        pressed = 16'h0000;
        do_reset();
        n_cmp++; if (KeyRow !== 4'b1110) begin n_bad++; $display("FAIL rst_row: got %b, expected 1110", KeyRow); end
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, expected 0", KeyValid); end
        n_cmp++; if (KeyCode !== 4'd0) begin n_bad++; $display("FAIL rst_code: got %0d, expected 0", KeyCode); end
        n_cmp++; if (KeyPressed !== 1'b0) begin n_bad++; $display("FAIL rst_pressed: got %b, expected 0", KeyPressed); end
        n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b, expected 0", Overrun); end
        clks(3);
        n_cmp++; if (KeyRow !== 4'b1110) begin n_bad++; $display("FAIL row0_hold: got %b, expected 1110", KeyRow); end
        clks(1);
        n_cmp++; if (KeyRow !== 4'b1101) begin n_bad++; $display("FAIL row1: got %b, expected 1101", KeyRow); end
        clks(FRAME - 4);
    endtask

    task automatic test_single_key();
        pressed = 16'h0001 << 9;
        exp_q.push_back(4'd9);
        clks(3*FRAME - 1);
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b, expected 0", KeyValid); end
        clks(1);
        n_cmp++; if (KeyValid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b, expected 1", KeyValid); end
        pop_expected();
        n_cmp++; if (KeyCode !== exp_code) begin n_bad++; $display("FAIL single_code: got %0d, expected %0d", KeyCode, exp_code); end
        n_cmp++; if (KeyPressed !== 1'b1) begin n_bad++; $display("FAIL single_pressed: got %b, expected 1", KeyPressed); end
        KeyAck = 1'b1;
        clks(1);
        KeyAck = 1'b0;
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL single_ack: got %b, expected 0", KeyValid); end
        clks(FRAME - 1);
        clks(10*FRAME);
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL no_repeat: got %b, expected 0", KeyValid); end
        n_cmp++; if (KeyPressed !== 1'b1) begin n_bad++; $display("FAIL held_level: got %b, expected 1", KeyPressed); end
        n_cmp++; if (ov_count !== 0) begin n_bad++; $display("FAIL held_overrun: got %0d, expected 0", ov_count); end
        pressed = 16'h0000;
        clks(3*FRAME - 1);
        n_cmp++; if (KeyPressed !== 1'b1) begin n_bad++; $display("FAIL release_early: got %b, expected 1", KeyPressed); end
        clks(1);
        n_cmp++; if (KeyPressed !== 1'b0) begin n_bad++; $display("FAIL release_done: got %b, expected 0", KeyPressed); end
    endtask

    task automatic test_bounce();
        pressed = 16'h0001 << 5;
        clks(2*FRAME);
        pressed = 16'h0000;
        clks(FRAME);
        pressed = 16'h0001 << 5;
        clks(2*FRAME);
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL bounce_valid: got %b, expected 0", KeyValid); end
        pressed = 16'h0000;
        clks(FRAME);
        n_cmp++; if (KeyPressed !== 1'b0) begin n_bad++; $display("FAIL bounce_pressed: got %b, expected 0", KeyPressed); end
        exp_q.push_back(4'd5);
        pressed = 16'h0001 << 5;
        clks(3*FRAME);
        n_cmp++; if (KeyValid !== 1'b1) begin n_bad++; $display("FAIL stable_valid: got %b, expected 1", KeyValid); end
        pop_expected();
        n_cmp++; if (KeyCode !== exp_code) begin n_bad++; $display("FAIL stable_code: got %0d, expected %0d", KeyCode, exp_code); end
        KeyAck = 1'b1;
        clks(1);
        KeyAck = 1'b0;
        clks(FRAME - 1);
        pressed = 16'h0000;
        clks(3*FRAME);
    endtask

    task automatic test_multi();
        pressed = (16'h0001 << 0) | (16'h0001 << 5);
        for (int f = 0; f < 6; f++) begin
            clks(FRAME);
            n_cmp++; if (KeyPressed !== 1'b0) begin n_bad++; $display("FAIL multi_pressed f%0d: got %b, expected 0", f, KeyPressed); end
            n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL multi_valid f%0d: got %b, expected 0", f, KeyValid); end
        end
        pressed = 16'h0000;
        clks(FRAME);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(4'd3);
        pressed = 16'h0001 << 3;
        clks(3*FRAME);
        pop_expected();
        n_cmp++; if (KeyCode !== exp_code || KeyValid !== 1'b1) begin n_bad++; $display("FAIL first_key: got v=%b code=%0d, expected v=1 code=%0d", KeyValid, KeyCode, exp_code); end
        pressed = 16'h0000;
        clks(3*FRAME);
        exp_q.push_back(4'd12);
        pressed = 16'h0001 << 12;
        ov0 = ov_count;
        clks(3*FRAME);
        pop_expected();
        n_cmp++; if (KeyCode !== exp_code || KeyValid !== 1'b1) begin n_bad++; $display("FAIL overwrite: got v=%b code=%0d, expected v=1 code=%0d", KeyValid, KeyCode, exp_code); end
        n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_pulse: got %b, expected 1", Overrun); end
        clks(1);
        n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_end: got %b, expected 0", Overrun); end
        n_cmp++; if (ov_count - ov0 !== 1) begin n_bad++; $display("FAIL overrun_count: got %0d, expected 1", ov_count - ov0); end
        clks(FRAME - 1);
        pressed = 16'h0000;
        clks(3*FRAME);
        exp_q.push_back(4'd12);
        pressed = 16'h0001 << 12;
        ov0 = ov_count;
        clks(3*FRAME - 1);
        KeyAck = 1'b1;
        clks(1);
        KeyAck = 1'b0;
        pop_expected();
        n_cmp++; if (KeyValid !== 1'b1) begin n_bad++; $display("FAIL ack_vs_event_valid: got %b, expected 1", KeyValid); end
        n_cmp++; if (KeyCode !== exp_code) begin n_bad++; $display("FAIL ack_vs_event_code: got %0d, expected %0d", KeyCode, exp_code); end
        n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL ack_vs_event_overrun: got %b, expected 0", Overrun); end
        clks(1);
        n_cmp++; if (ov_count !== ov0) begin n_bad++; $display("FAIL ack_vs_event_count: got %0d, expected %0d", ov_count, ov0); end
        clks(FRAME - 2);
        pressed = 16'h0000;
        clks(3*FRAME);
    endtask

    task automatic test_reset_mid_debounce();
        pressed = 16'h0001 << 6;
        clks(FRAME + 8);
        do_reset();
        n_cmp++; if (KeyRow !== 4'b1110) begin n_bad++; $display("FAIL mid_rst_row: got %b, expected 1110", KeyRow); end
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b, expected 0", KeyValid); end
        n_cmp++; if (KeyCode !== 4'd0) begin n_bad++; $display("FAIL mid_rst_code: got %0d, expected 0", KeyCode); end
        n_cmp++; if (KeyPressed !== 1'b0 || Overrun !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got p=%b o=%b, expected 0 0", KeyPressed, Overrun); end
        exp_q.push_back(4'd6);
        clks(3*FRAME - 1);
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL fresh_early: got %b, expected 0", KeyValid); end
        clks(1);
        n_cmp++; if (KeyValid !== 1'b1) begin n_bad++; $display("FAIL fresh_valid: got %b, expected 1", KeyValid); end
        pop_expected();
        n_cmp++; if (KeyCode !== exp_code) begin n_bad++; $display("FAIL fresh_code: got %0d, expected %0d", KeyCode, exp_code); end
        pressed = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_reset_mid_debounce();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
